// File: rtl/fifo_credit_sender.sv
// fifo_credit_sender: credit-gated forwarder from a valid/ready stream into a remote sync FIFO
// Ports: clk (state updates on falling edge), reset (async, active low),
//   in_data/in_valid/in_ready (local stream), push/push_data (remote FIFO write strobe),
//   pop_ret (one credit returned per high cycle), credits (free remote slots),
//   idle (running, nothing held, all credits home), err_overflow (sticky surplus credit return)
module fifo_credit_sender #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop_ret,
  output logic [CNT_WIDTH-1:0]  credits,
  output logic                  idle,
  output logic                  err_overflow
);
  typedef enum logic [1:0] {INIT, RUN, STALL} state_t;
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);
  state_t                  state, state_next;
  logic                    hold_valid, hold_valid_next, accept, err_next;
  logic [DATA_WIDTH-1:0]   hold_data;
  logic [CNT_WIDTH-1:0]    credits_next;
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state        <= INIT;
      credits      <= FULL;
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_next;
      credits      <= credits_next;
      hold_valid   <= hold_valid_next;
      err_overflow <= err_next;
      if (accept) hold_data <= in_data;
    end
  end
  always_comb begin
    push            = hold_valid && credits != '0 && state != INIT;
    in_ready        = state != INIT && (!hold_valid || push);
    accept          = in_valid && in_ready;
    hold_valid_next = accept || (hold_valid && !push);
    // a simultaneous push and return cancel; a return with all credits home is dropped
    credits_next    = (push == pop_ret) ? credits :
                      push ? credits - 1'b1 :
                      (credits == FULL) ? credits : credits + 1'b1;
    err_next        = err_overflow || (pop_ret && !push && credits == FULL);
    state_next      = (state == INIT) ? RUN :
                      (state == RUN) ? ((credits_next == '0 && hold_valid_next) ? STALL : RUN) :
                      ((credits_next != '0) ? RUN : STALL);
  end
  assign push_data = hold_data;
  assign idle      = state == RUN && !hold_valid && credits == FULL;
endmodule

// File: tb/tb_fifo_credit_sender.sv
// tb_fifo_credit_sender: directed and random checks of fifo_credit_sender against a queue-based model
module tb_fifo_credit_sender;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        push;
  logic [15:0] push_data;
  logic        pop_ret = 1'b0;
  logic [3:0]  credits;
  logic        idle;
  logic        err_overflow;
  int          checks = 0;
  int          errors = 0;
  int          m_cred;
  logic [15:0] m_hold[$];
  logic [15:0] dut_pushed[$];
  bit          m_started, m_err, last_acc;
  fifo_credit_sender #(.DATA_WIDTH(16), .DEPTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .push(push), .push_data(push_data), .pop_ret(pop_ret), .credits(credits),
    .idle(idle), .err_overflow(err_overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_cred = 8;
    m_hold.delete();
    m_started = 0;
    m_err = 0;
  endtask
  task automatic step(input bit v, input logic [15:0] d, input bit p);
    bit ep, er;
    in_valid = v;
    in_data  = d;
    pop_ret  = p;
    #1;
    ep = m_hold.size() > 0 && m_cred > 0 && m_started;
    er = m_started && (m_hold.size() == 0 || ep);
    chk("push", push, ep);
    chk("in_ready", in_ready, er);
    chk("credits", credits, m_cred);
    chk("idle", idle, m_started && m_hold.size() == 0 && m_cred == 8);
    chk("err_overflow", err_overflow, m_err);
    if (ep) chk("push_data", push_data, m_hold[0]);
    if (push) dut_pushed.push_back(push_data);
    last_acc = v && er;
    @(negedge clk);
    if (ep) m_hold.delete(0);
    if (v && er) m_hold.push_back(d);
    if (ep && !p) m_cred--;
    else if (p && !ep) begin
      if (m_cred == 8) m_err = 1;
      else m_cred++;
    end
    m_started = 1;
    @(posedge clk);
  endtask
  task automatic stream_nine();
    int nxt = 1;
    repeat (14) begin
      step(nxt <= 9, 16'(nxt), 0);
      if (last_acc) nxt++;
    end
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    chk("rst_push", push, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_credits", credits, 8);
    chk("rst_err", err_overflow, 0);
    reset = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("idle_after_init", idle, 1);
    dut_pushed.delete();
    stream_nine();
    chk("stream_count", dut_pushed.size(), 8);
    for (int i = 0; i < 8 && i < dut_pushed.size(); i++) chk("stream_word", dut_pushed[i], i + 1);
    chk("stall_credits", credits, 0);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_push_data", push_data, 16'h0009);
    dut_pushed.delete();
    step(0, 0, 1);
    step(0, 0, 0);
    chk("ret_push_count", dut_pushed.size(), 1);
    if (dut_pushed.size() > 0) chk("ret_push_word", dut_pushed[0], 16'h0009);
    chk("ret_credits", credits, 0);
    chk("ret_in_ready", in_ready, 1);
    repeat (3) step(0, 0, 1);
    chk("three_credits", credits, 3);
    step(1, 16'h0100, 0);
    step(1, 16'h0101, 1);
    chk("pushpop_credits", credits, 3);
    chk("pushpop_refill", push_data, 16'h0101);
    step(0, 0, 0);
    repeat (6) step(0, 0, 1);
    chk("idle_full", idle, 1);
    chk("no_err_yet", err_overflow, 0);
    step(0, 0, 1);
    chk("ovf_credits", credits, 8);
    chk("ovf_err", err_overflow, 1);
    repeat (3) step(0, 0, 0);
    stream_nine();
    chk("stall_again", credits, 0);
    #2 reset = 1'b0;
    #1;
    chk("async_push", push, 0);
    chk("async_credits", credits, 8);
    chk("async_in_ready", in_ready, 0);
    chk("async_err", err_overflow, 0);
    model_reset();
    @(posedge clk);
    reset = 1'b1;
    dut_pushed.delete();
    repeat (12) step(0, 0, 0);
    chk("no_stale_push", dut_pushed.size(), 0);
    repeat (400) step($urandom_range(0, 1), 16'($urandom), $urandom_range(0, 2) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
